// File: rtl/tcdm_req_arbiter_pkg.sv
// Shared constants, request word layout and helpers for the TCDM request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tcdm_arb_pkg;

  localparam int TCDM_REQ_W   = 57;
  localparam int TCDM_RDATA_W = 32;

  // Request word layout, LSB offsets: {addr[19:0], be[3:0], wdata[31:0], wen}
  localparam int REQ_WEN_LSB   = 0;
  localparam int REQ_WDATA_LSB = 1;
  localparam int REQ_BE_LSB    = 33;
  localparam int REQ_ADDR_LSB  = 37;

  typedef struct packed {
    logic [19:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wen;
  } req_t;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tcdm_req_arbiter_if.sv
// Requester-side and downstream-side bundles for the TCDM request arbiter.
// Latency: n/a (wiring only).
// Backpressure: req/gnt handshake per port and downstream; responses are strobes with no stall.
//
// tcdm_port_if : port_req, port_req_data (requester -> arbiter), port_gnt, port_valid,
//                port_rdata (arbiter -> requesters). master = requesters, slave = arbiter.
// tcdm_bus_if  : tcdm_req, tcdm_req_data (arbiter -> bridge), tcdm_gnt, tcdm_valid,
//                tcdm_rdata (bridge -> arbiter). master = arbiter, slave = bridge.
interface tcdm_port_if #(
  parameter int NUM_PORTS = 4
);
  import tcdm_arb_pkg::*;

  logic [NUM_PORTS-1:0]                 port_req;
  logic [NUM_PORTS-1:0][TCDM_REQ_W-1:0] port_req_data;
  logic [NUM_PORTS-1:0]                 port_gnt;
  logic [NUM_PORTS-1:0]                 port_valid;
  logic [TCDM_RDATA_W-1:0]              port_rdata;

  modport master (
    output port_req, port_req_data,
    input  port_gnt, port_valid, port_rdata
  );

  modport slave (
    input  port_req, port_req_data,
    output port_gnt, port_valid, port_rdata
  );
endinterface

interface tcdm_bus_if;
  import tcdm_arb_pkg::*;

  logic                    tcdm_req;
  logic [TCDM_REQ_W-1:0]   tcdm_req_data;
  logic                    tcdm_gnt;
  logic                    tcdm_valid;
  logic [TCDM_RDATA_W-1:0] tcdm_rdata;

  modport master (
    output tcdm_req, tcdm_req_data,
    input  tcdm_gnt, tcdm_valid, tcdm_rdata
  );

  modport slave (
    input  tcdm_req, tcdm_req_data,
    output tcdm_gnt, tcdm_valid, tcdm_rdata
  );
endinterface

// File: rtl/tcdm_req_arbiter_id_fifo.sv
// In-order FIFO of granted port indices, one entry per request awaiting its response.
// Latency: push visible at head the cycle after; head is combinational from storage.
// Backpressure: push ignored when full, pop ignored when empty; caller uses full/empty.
//
// Ports: clk, rst_n (async active-low); push/push_dat write; pop removes head;
//        head_dat oldest entry; full, empty, count current occupancy.
module tcdm_arb_id_fifo
  import tcdm_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_req_arbiter.sv
// Round-robin arbiter funnelling NUM_PORTS eFPGA requesters onto one TCDM bridge port.
// Latency: grant and request data are combinational (zero cycles); responses routed same cycle.
// Backpressure: downstream tcdm_gnt stalls the held winner; at MAX_OUTST outstanding no request issues.
//
// Ports: efpga_clk, efpga_rst_n (async active-low); ports (tcdm_port_if.slave) requester side;
//        bus (tcdm_bus_if.master) downstream side; outst_cnt outstanding count;
//        resp_err sticky flag for a response arriving with nothing outstanding.
module tcdm_req_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                           efpga_clk,
  input  logic                           efpga_rst_n,
  tcdm_port_if.slave                     ports,
  tcdm_bus_if.master                     bus,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
  output logic                           resp_err
);

  localparam int IW = idx_w(NUM_PORTS);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] winner;
  logic [IW-1:0] hold_idx;
  logic          hold_vld;
  logic [IW-1:0] head_idx;
  logic          any_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic          req_out;
  logic          hs;
  logic          rsp_ok;

  // First requesting port at or after the priority pointer.
  always_comb begin
    int  cand;
    logic found;
    rr_idx = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      if (!found && ports.port_req[cand]) begin
        found  = 1'b1;
        rr_idx = IW'(cand);
      end
    end
  end

  // A request that was presented but stalled last cycle keeps the bus, so a
  // newly raised higher-priority port cannot swap the data under a pending grant.
  assign winner  = (hold_vld && ports.port_req[hold_idx]) ? hold_idx : rr_idx;
  assign any_req = |ports.port_req;
  // Full is taken from the registered count, so a response popping this cycle
  // does not open a slot until the next one.
  assign req_out = any_req && !fifo_full;
  assign hs      = req_out && bus.tcdm_gnt;
  assign rsp_ok  = bus.tcdm_valid && !fifo_empty;

  assign bus.tcdm_req      = req_out;
  assign bus.tcdm_req_data = ports.port_req_data[winner];
  assign ports.port_rdata  = bus.tcdm_rdata;

  always_comb begin
    ports.port_gnt         = '0;
    ports.port_gnt[winner] = hs;
  end

  always_comb begin
    ports.port_valid           = '0;
    ports.port_valid[head_idx] = rsp_ok;
  end

  always_ff @(posedge efpga_clk or negedge efpga_rst_n) begin
    if (!efpga_rst_n) begin
      rr_ptr   <= '0;
      hold_vld <= 1'b0;
      hold_idx <= '0;
      resp_err <= 1'b0;
    end else begin
      hold_vld <= req_out && !bus.tcdm_gnt;
      hold_idx <= winner;
      if (hs) begin
        rr_ptr <= (winner == IW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
      end
      if (bus.tcdm_valid && fifo_empty) begin
        resp_err <= 1'b1;
      end
    end
  end

  tcdm_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk      (efpga_clk),
    .rst_n    (efpga_rst_n),
    .push     (hs),
    .push_dat (winner),
    .pop      (bus.tcdm_valid),
    .head_dat (head_idx),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outst_cnt)
  );

endmodule

// File: tb/tb_tcdm_req_arbiter.sv
// Scoreboard bench for tcdm_req_arbiter: stimulus queues expected grants and responses,
// a negedge monitor pops and compares whenever a grant or response strobe appears.
// The downstream bridge is modelled by directly driven tcdm_gnt/tcdm_valid/tcdm_rdata.
module tb_tcdm_req_arbiter;
  import tcdm_arb_pkg::*;

  localparam int NP = 4;
  localparam int MO = 4;

  typedef struct {
    int                    port;
    logic [TCDM_REQ_W-1:0] dat;
  } gexp_t;

  typedef struct {
    int                      port;
    logic [TCDM_RDATA_W-1:0] rdata;
  } rexp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] outst_cnt;
  logic       resp_err;

  int n_pass  = 0;
  int n_total = 0;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t mg;
  rexp_t mr;

  int seq6[3] = '{0, 1, 3};

  always #5 clk = ~clk;

  tcdm_port_if #(.NUM_PORTS(NP)) pif();
  tcdm_bus_if bif();

  tcdm_req_arbiter #(
    .NUM_PORTS (NP),
    .MAX_OUTST (MO)
  ) dut (
    .efpga_clk   (clk),
    .efpga_rst_n (rst_n),
    .ports       (pif.slave),
    .bus         (bif.master),
    .outst_cnt   (outst_cnt),
    .resp_err    (resp_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [TCDM_REQ_W-1:0] mk(input int p, input int tag);
    req_t r;
    r.addr  = 20'h10000 + 20'(p * 256) + 20'(tag);
    r.be    = 4'(p + 1);
    r.wdata = 32'h5A00_0000 + 32'(p * 16) + 32'(tag);
    r.wen   = p[0];
    return r;
  endfunction

  task automatic set_reqs(input logic [NP-1:0] mask, input int tag);
    for (int p = 0; p < NP; p++) begin
      pif.port_req[p]      = mask[p];
      pif.port_req_data[p] = mk(p, tag);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input int p, input int tag);
    gexp_t g;
    g.port = p;
    g.dat  = mk(p, tag);
    gq.push_back(g);
  endtask

  task automatic push_r(input int p, input logic [31:0] d);
    rexp_t r;
    r.port  = p;
    r.rdata = d;
    rq.push_back(r);
  endtask

  // Downstream bridge is reset together with the arbiter: its strobes drop.
  task automatic do_reset();
    set_reqs('0, 0);
    bif.tcdm_gnt   = 1'b0;
    bif.tcdm_valid = 1'b0;
    bif.tcdm_rdata = '0;
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
  endtask

  // Drain n responses whose port order is given by ports_in, with rdata base+k.
  task automatic drain(input int n, input int ports_in[4], input logic [31:0] base, input string nm);
    for (int k = 0; k < n; k++) begin
      bif.tcdm_valid = 1'b1;
      bif.tcdm_rdata = base + 32'(k);
      push_r(ports_in[k], base + 32'(k));
      @(negedge clk);
      chk({nm, "_drain_cnt"}, 64'(outst_cnt), 64'(n - k));
      next_cyc();
    end
    bif.tcdm_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_drained_cnt"}, 64'(outst_cnt), 64'(0));
    next_cyc();
  endtask

  always @(negedge clk) begin
    if (pif.port_gnt != '0) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 64'(pif.port_gnt), 64'(0));
      end else begin
        mg = gq.pop_front();
        chk("gnt_port", 64'(pif.port_gnt), 64'(1) << mg.port);
        chk("gnt_data", 64'(bif.tcdm_req_data), 64'(mg.dat));
      end
    end
    if (pif.port_valid != '0) begin
      if (rq.size() == 0) begin
        chk("rsp_unexpected", 64'(pif.port_valid), 64'(0));
      end else begin
        mr = rq.pop_front();
        chk("rsp_port", 64'(pif.port_valid), 64'(1) << mr.port);
        chk("rsp_rdata", 64'(pif.port_rdata), 64'(mr.rdata));
      end
    end
  end

  initial begin
    int ord[4];

    set_reqs('0, 0);
    bif.tcdm_gnt   = 1'b0;
    bif.tcdm_valid = 1'b0;
    bif.tcdm_rdata = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_gnt", 64'(pif.port_gnt), 64'(0));
    chk("rst_valid", 64'(pif.port_valid), 64'(0));
    chk("rst_tcdm_req", 64'(bif.tcdm_req), 64'(0));
    chk("rst_cnt", 64'(outst_cnt), 64'(0));
    chk("rst_err", 64'(resp_err), 64'(0));
    next_cyc();
    rst_n = 1'b1;

    // Ports 0 and 2 alternate; count climbs one per grant.
    set_reqs(4'b0101, 1);
    bif.tcdm_gnt = 1'b1;
    ord = '{0, 2, 0, 2};
    for (int k = 0; k < 4; k++) begin
      push_g(ord[k], 1);
      @(negedge clk);
      chk("t1_cnt", 64'(outst_cnt), 64'(k));
      chk("t1_req", 64'(bif.tcdm_req), 64'(1));
      next_cyc();
    end
    set_reqs('0, 1);
    bif.tcdm_gnt = 1'b0;
    drain(4, ord, 32'h1111_0000, "t1");

    // All four request: grants 0,1,2,3 then full.
    do_reset();
    set_reqs(4'b1111, 2);
    bif.tcdm_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_g(k, 2);
      next_cyc();
    end
    @(negedge clk);
    chk("t2_req_full", 64'(bif.tcdm_req), 64'(0));
    chk("t2_cnt_full", 64'(outst_cnt), 64'(4));
    chk("t2_no_gnt", 64'(pif.port_gnt), 64'(0));
    next_cyc();

    // Response at full: routed to port 0, no grant that cycle, grant next cycle.
    bif.tcdm_valid = 1'b1;
    bif.tcdm_rdata = 32'hDEAD_BEEF;
    push_r(0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t3_req_blocked", 64'(bif.tcdm_req), 64'(0));
    chk("t3_valid0", 64'(pif.port_valid), 64'(1));
    chk("t3_rdata", 64'(pif.port_rdata), 64'(32'hDEAD_BEEF));
    next_cyc();
    bif.tcdm_valid = 1'b0;
    push_g(0, 2);
    @(negedge clk);
    chk("t3_cnt_after_pop", 64'(outst_cnt), 64'(3));
    chk("t3_req_resume", 64'(bif.tcdm_req), 64'(1));
    next_cyc();
    set_reqs('0, 2);
    bif.tcdm_gnt = 1'b0;
    ord = '{1, 2, 3, 0};
    drain(4, ord, 32'h3333_0000, "t3");

    // Port 1 stalled for three cycles; port 0 must not preempt.
    do_reset();
    set_reqs(4'b0010, 4);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_reqs(4'b0011, 4);
      @(negedge clk);
      chk("t4_stall_req", 64'(bif.tcdm_req), 64'(1));
      chk("t4_stall_data", 64'(bif.tcdm_req_data), 64'(mk(1, 4)));
      next_cyc();
    end
    bif.tcdm_gnt = 1'b1;
    push_g(1, 4);
    @(negedge clk);
    chk("t4_gnt1", 64'(pif.port_gnt), 64'(4'b0010));
    next_cyc();
    set_reqs(4'b0001, 4);
    push_g(0, 4);
    next_cyc();
    set_reqs('0, 4);
    bif.tcdm_gnt = 1'b0;
    @(negedge clk);
    chk("t4_cnt", 64'(outst_cnt), 64'(2));
    next_cyc();
    ord = '{1, 0, 0, 0};
    drain(2, ord, 32'h4444_0000, "t4");

    // Stray response with nothing outstanding.
    do_reset();
    @(negedge clk);
    chk("t5_err_pre", 64'(resp_err), 64'(0));
    next_cyc();
    bif.tcdm_valid = 1'b1;
    bif.tcdm_rdata = 32'h0000_0BAD;
    @(negedge clk);
    chk("t5_no_valid", 64'(pif.port_valid), 64'(0));
    next_cyc();
    bif.tcdm_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 64'(resp_err), 64'(1));
    chk("t5_cnt", 64'(outst_cnt), 64'(0));
    repeat (3) next_cyc();
    @(negedge clk);
    chk("t5_err_held", 64'(resp_err), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_err_clr", 64'(resp_err), 64'(0));
    next_cyc();
    rst_n = 1'b1;

    // Ports 0,1,3 stream; 20 cycles of simultaneous push and pop wrap the FIFO.
    do_reset();
    set_reqs(4'b1011, 6);
    bif.tcdm_gnt = 1'b1;
    for (int j = 0; j < 2; j++) begin
      push_g(seq6[j % 3], 6);
      next_cyc();
    end
    for (int i = 0; i < 20; i++) begin
      push_g(seq6[(i + 2) % 3], 6);
      bif.tcdm_valid = 1'b1;
      bif.tcdm_rdata = 32'hC0DE_0000 + 32'(i);
      push_r(seq6[i % 3], 32'hC0DE_0000 + 32'(i));
      @(negedge clk);
      chk("t6_cnt_const", 64'(outst_cnt), 64'(2));
      next_cyc();
    end
    set_reqs('0, 6);
    bif.tcdm_gnt   = 1'b0;
    bif.tcdm_valid = 1'b0;
    @(negedge clk);
    chk("t6_cnt_end", 64'(outst_cnt), 64'(2));
    next_cyc();
    ord = '{3, 0, 0, 0};
    drain(2, ord, 32'h6666_0000, "t6");

    repeat (2) next_cyc();
    chk("gnt_queue_empty", 64'(gq.size()), 64'(0));
    chk("rsp_queue_empty", 64'(rq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tcdm_req_arbiter.md
TCDM_REQ_ARBITER -- requirements
Module: tcdm_req_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, SHALL set the number of eFPGA requester ports (legal range 2..8).
REQ-002 Parameter MAX_OUTST, default 4, SHALL set the maximum number of granted requests still awaiting a response (legal range 1..8).
REQ-003 Port efpga_clk  in  1  SHALL be the single clock; all state is in this domain.
REQ-004 Port efpga_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port port_req  in  NUM_PORTS  SHALL be the per-port request, held until granted.
REQ-006 Port port_req_data  in  NUM_PORTS x 57  SHALL carry per-port {addr[19:0], be[3:0], wdata[31:0], wen}.
REQ-007 Port port_gnt  out  NUM_PORTS  SHALL be the per-port grant, at most one bit high per cycle.
REQ-008 Port port_valid  out  NUM_PORTS  SHALL be the per-port response strobe, at most one bit high per cycle.
REQ-009 Port port_rdata  out  32  SHALL be the response data, shared by all ports and qualified by port_valid.
REQ-010 Port tcdm_req  out  1  SHALL be the request to the downstream TCDM bridge.
REQ-011 Port tcdm_gnt  in  1  SHALL be the downstream grant.
REQ-012 Port tcdm_req_data  out  57  SHALL carry the winning port's request data.
REQ-013 Port tcdm_valid  in  1  SHALL be the downstream single-cycle response strobe.
REQ-014 Port tcdm_rdata  in  32  SHALL be the downstream response data.
REQ-015 Port outst_cnt  out  clog2(MAX_OUTST+1)  SHALL report the current outstanding-request count.
REQ-016 Port resp_err  out  1  SHALL be a sticky flag for a response received with nothing outstanding.

Function
REQ-017 Every granted request (read or write) SHALL receive exactly one downstream response, in request order.
REQ-018 Arbitration SHALL be round-robin; the priority pointer SHALL start at port 0 and move to (winner+1) mod NUM_PORTS only on a completed handshake.
REQ-019 tcdm_req SHALL be high combinationally when any port_req is high and outst_cnt < MAX_OUTST.
REQ-020 tcdm_req_data SHALL equal port_req_data of the current winner in the same cycle, with no registering.
REQ-021 The winner's port_gnt SHALL equal tcdm_gnt && tcdm_req in the same cycle (zero latency); all other port_gnt bits SHALL be 0.
REQ-022 The winner SHALL be held stable while tcdm_req is high and tcdm_gnt is low; a higher-priority port raising req SHALL NOT preempt it.
REQ-023 Each handshake SHALL push the winner index into an in-order ID FIFO of depth MAX_OUTST.
REQ-024 Each tcdm_valid SHALL pop the ID FIFO, assert port_valid[head] in that same cycle, and drive port_rdata = tcdm_rdata.
REQ-025 When outst_cnt == MAX_OUTST, no grant SHALL occur, even if a response pops the FIFO in the same cycle.
REQ-026 A simultaneous push and pop SHALL leave outst_cnt unchanged.
REQ-027 tcdm_valid with an empty ID FIFO SHALL assert no port_valid, leave the FIFO and count unchanged, and set resp_err until reset.
REQ-028 The ID FIFO read and write pointers SHALL wrap modulo MAX_OUTST.

Reset
REQ-029 On efpga_rst_n low the block SHALL asynchronously clear: priority pointer to 0, FIFO pointers, outst_cnt = 0, resp_err = 0; port_gnt, port_valid and tcdm_req then evaluate to 0.
REQ-030 Reset mid-transaction SHALL discard all outstanding IDs; the bench SHALL reset the downstream bridge together with this block.

Structure
REQ-031 Package tcdm_arb_pkg SHALL hold TCDM_REQ_W = 57, TCDM_RDATA_W = 32, the field offsets of the request word, and the port-index width function.
REQ-032 The ID FIFO SHALL be a sub-module tcdm_arb_id_fifo (synchronous, single clock, provides a count output).

Verification
REQ-033 Ports 0 and 2 request continuously with tcdm_gnt = 1 and MAX_OUTST never reached -> grants alternate 0,2,0,2; outst_cnt rises by 1 per cycle until responses return.
REQ-034 All 4 ports request, tcdm_gnt = 1, no tcdm_valid -> exactly 4 grants (ports 0,1,2,3), then tcdm_req = 0 and outst_cnt = 4.
REQ-035 With outst_cnt = 4, one tcdm_valid carrying rdata 0xDEADBEEF -> port_valid[0] = 1 and port_rdata = 0xDEADBEEF that cycle; no grant that cycle; grant resumes next cycle.
REQ-036 Port 1 requesting, tcdm_gnt = 0 for 3 cycles while port 0 raises req -> tcdm_req_data stays at port 1's data; port_gnt[1] asserts in the cycle tcdm_gnt = 1.
REQ-037 tcdm_valid pulsed after reset with nothing outstanding -> port_valid = 0, resp_err = 1 and held; efpga_rst_n pulse -> resp_err = 0.
REQ-038 Sustained traffic with simultaneous push and pop every cycle for 20 cycles -> outst_cnt constant, responses routed in grant order, with pointer wrap exercised.
